// File: rtl/ds_es_hazard_stage.sv
// Decode-to-execute pipeline register with load-use stall / branch flush control.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module ds_es_hazard_stage #(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int NOP_OPCODE   = 0,
  parameter int FLUSH_CYCLES = 2   // legal range 1..7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    d_i_valid,
  input  logic [OPCODE_WIDTH-1:0] d_i_opcode,
  input  logic [AWIDTH-1:0]       d_i_addr_rs1,
  input  logic [AWIDTH-1:0]       d_i_addr_rs2,
  input  logic [AWIDTH-1:0]       d_i_addr_rd,
  input  logic                    d_i_regwrite,
  input  logic [DWIDTH-1:0]       d_i_data_rs1,
  input  logic [DWIDTH-1:0]       d_i_data_rs2,
  input  logic [DWIDTH-1:0]       d_i_imm,
  input  logic                    f_i_stall,
  input  logic                    es_i_flush,
  output logic                    ds_es_o_valid,
  output logic [OPCODE_WIDTH-1:0] ds_es_o_opcode,
  output logic [AWIDTH-1:0]       ds_es_o_addr_rs1,
  output logic [AWIDTH-1:0]       ds_es_o_addr_rs2,
  output logic [AWIDTH-1:0]       ds_es_o_addr_rd,
  output logic                    ds_es_o_regwrite,
  output logic [DWIDTH-1:0]       ds_es_o_data_rs1,
  output logic [DWIDTH-1:0]       ds_es_o_data_rs2,
  output logic [DWIDTH-1:0]       ds_es_o_imm,
  output logic                    h_o_pc_en,
  output logic                    h_o_fd_en,
  output logic                    h_o_fd_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             h_o_stall_cnt,
  output logic [31:0]             h_o_flush_cnt,
  output logic [31:0]             h_o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [AWIDTH-1:0]       rs1;
    logic [AWIDTH-1:0]       rs2;
    logic [AWIDTH-1:0]       rd;
    logic                    regwrite;
    logic [DWIDTH-1:0]       data_rs1;
    logic [DWIDTH-1:0]       data_rs2;
    logic [DWIDTH-1:0]       imm;
  } stage_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  stage_t     stage_q, stage_d, bubble, incoming;
  logic       accept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= RUN;
      cnt     <= '0;
      stage_q <= bubble;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      stage_q <= stage_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: flush beats stall; stall is honoured only from RUN
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      RUN: begin
        if (es_i_flush) begin
          cnt_next   = FLUSH_LOAD;
          state_next = MULTI_FLUSH ? FLUSH : RUN;
        end else if (f_i_stall) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (es_i_flush) begin
          cnt_next   = FLUSH_LOAD;
          state_next = MULTI_FLUSH ? FLUSH : RUN;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        if (es_i_flush) begin
          cnt_next = FLUSH_LOAD;
        end else begin
          cnt_next   = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
          state_next = (cnt <= 3'd1) ? RUN : FLUSH;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: payload selection and hold enables
  // ---------------------------------------------------------------------------
  always_comb begin
    bubble        = '0;
    bubble.opcode = OPCODE_WIDTH'(NOP_OPCODE);

    incoming.valid    = d_i_valid;
    incoming.opcode   = d_i_opcode;
    incoming.rs1      = d_i_addr_rs1;
    incoming.rs2      = d_i_addr_rs2;
    incoming.rd       = d_i_addr_rd;
    incoming.regwrite = d_i_regwrite;
    incoming.data_rs1 = d_i_data_rs1;
    incoming.data_rs2 = d_i_data_rs2;
    incoming.imm      = d_i_imm;

    // STALL always re-captures the held instruction; RUN only when no stall.
    accept = !es_i_flush &&
             ((state == RUN && !f_i_stall) || state == STALL);

    stage_d = (accept && d_i_valid) ? incoming : bubble;

    h_o_pc_en    = !(state == RUN && f_i_stall && !es_i_flush);
    h_o_fd_en    = h_o_pc_en;
    h_o_fd_flush = es_i_flush || (state == FLUSH);
  end

  assign ds_es_o_valid    = stage_q.valid;
  assign ds_es_o_opcode   = stage_q.opcode;
  assign ds_es_o_addr_rs1 = stage_q.rs1;
  assign ds_es_o_addr_rs2 = stage_q.rs2;
  assign ds_es_o_addr_rd  = stage_q.rd;
  assign ds_es_o_regwrite = stage_q.regwrite;
  assign ds_es_o_data_rs1 = stage_q.data_rs1;
  assign ds_es_o_data_rs2 = stage_q.data_rs2;
  assign ds_es_o_imm      = stage_q.imm;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (state_next == STALL) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (es_i_flush)          flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (!stage_d.valid)      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign h_o_stall_cnt  = stall_cnt_q;
  assign h_o_flush_cnt  = flush_cnt_q;
  assign h_o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ds_es_hazard_stage.sv
// Self-checking bench for ds_es_hazard_stage: directed hazard scenarios followed
// by randomized traffic compared against a bubble-budget reference model.
module tb_ds_es_hazard_stage;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int OW  = 6;
  localparam int NOP = 0;
  localparam int FC  = 2;

  typedef struct packed {
    logic          valid;
    logic [OW-1:0] opcode;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
  } pl_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          d_i_valid = 1'b0;
  logic [OW-1:0] d_i_opcode = '0;
  logic [AW-1:0] d_i_addr_rs1 = '0, d_i_addr_rs2 = '0, d_i_addr_rd = '0;
  logic          d_i_regwrite = 1'b0;
  logic [DW-1:0] d_i_data_rs1 = '0, d_i_data_rs2 = '0, d_i_imm = '0;
  logic          f_i_stall = 1'b0, es_i_flush = 1'b0;
  logic          ds_es_o_valid, ds_es_o_regwrite;
  logic [OW-1:0] ds_es_o_opcode;
  logic [AW-1:0] ds_es_o_addr_rs1, ds_es_o_addr_rs2, ds_es_o_addr_rd;
  logic [DW-1:0] ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm;
  logic          h_o_pc_en, h_o_fd_en, h_o_fd_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   h_o_stall_cnt, h_o_flush_cnt, h_o_bubble_cnt;
`endif

  ds_es_hazard_stage #(
    .AWIDTH(AW), .DWIDTH(DW), .OPCODE_WIDTH(OW), .NOP_OPCODE(NOP), .FLUSH_CYCLES(FC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .d_i_valid(d_i_valid), .d_i_opcode(d_i_opcode),
    .d_i_addr_rs1(d_i_addr_rs1), .d_i_addr_rs2(d_i_addr_rs2), .d_i_addr_rd(d_i_addr_rd),
    .d_i_regwrite(d_i_regwrite), .d_i_data_rs1(d_i_data_rs1),
    .d_i_data_rs2(d_i_data_rs2), .d_i_imm(d_i_imm),
    .f_i_stall(f_i_stall), .es_i_flush(es_i_flush),
    .ds_es_o_valid(ds_es_o_valid), .ds_es_o_opcode(ds_es_o_opcode),
    .ds_es_o_addr_rs1(ds_es_o_addr_rs1), .ds_es_o_addr_rs2(ds_es_o_addr_rs2),
    .ds_es_o_addr_rd(ds_es_o_addr_rd), .ds_es_o_regwrite(ds_es_o_regwrite),
    .ds_es_o_data_rs1(ds_es_o_data_rs1), .ds_es_o_data_rs2(ds_es_o_data_rs2),
    .ds_es_o_imm(ds_es_o_imm),
    .h_o_pc_en(h_o_pc_en), .h_o_fd_en(h_o_fd_en), .h_o_fd_flush(h_o_fd_flush)
`ifdef HAZARD_PERF_CNT_EN
    , .h_o_stall_cnt(h_o_stall_cnt), .h_o_flush_cnt(h_o_flush_cnt),
    .h_o_bubble_cnt(h_o_bubble_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: forced-bubble budget plus a "stall already served" flag.
  int          bub_left    = 0;
  bit          stall_taken = 1'b0;
  bit          known       = 1'b0;
  pl_t         exp_q;
  logic [31:0] m_stall_cnt = '0, m_flush_cnt = '0, m_bubble_cnt = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pl_t bubble_pl();
    pl_t b;
    b        = '0;
    b.opcode = OW'(NOP);
    return b;
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    p.valid    = ($urandom_range(0, 4) != 0);
    p.opcode   = OW'($urandom);
    p.rs1      = AW'($urandom);
    p.rs2      = AW'($urandom);
    p.rd       = AW'($urandom);
    p.regwrite = 1'($urandom);
    p.d1       = $urandom;
    p.d2       = $urandom;
    p.imm      = $urandom;
    return p;
  endfunction

  // One clock cycle: drive at negedge, check hold outputs, clock, check registers.
  task automatic step(input bit rst, input pl_t in, input bit stall, input bit flush);
    bit exp_pc, exp_fdf;
    @(negedge i_clk);
    i_rst        = rst;
    d_i_valid    = in.valid;
    d_i_opcode   = in.opcode;
    d_i_addr_rs1 = in.rs1;
    d_i_addr_rs2 = in.rs2;
    d_i_addr_rd  = in.rd;
    d_i_regwrite = in.regwrite;
    d_i_data_rs1 = in.d1;
    d_i_data_rs2 = in.d2;
    d_i_imm      = in.imm;
    f_i_stall    = stall;
    es_i_flush   = flush;
    #1;
    if (known) begin
      exp_pc  = !(bub_left == 0 && !stall_taken && stall && !flush);
      exp_fdf = flush || (bub_left > 0);
      check("pc_en",    64'(h_o_pc_en),    64'(exp_pc));
      check("fd_en",    64'(h_o_fd_en),    64'(exp_pc));
      check("fd_flush", 64'(h_o_fd_flush), 64'(exp_fdf));
    end
    @(posedge i_clk);
    if (rst) begin
      exp_q        = bubble_pl();
      bub_left     = 0;
      stall_taken  = 1'b0;
      m_stall_cnt  = '0;
      m_flush_cnt  = '0;
      m_bubble_cnt = '0;
      known        = 1'b1;
    end else begin
      if (flush) begin
        exp_q       = bubble_pl();
        bub_left    = FC - 1;
        stall_taken = 1'b0;
        m_flush_cnt = m_flush_cnt + 1;
      end else if (bub_left > 0) begin
        exp_q    = bubble_pl();
        bub_left = bub_left - 1;
      end else if (stall && !stall_taken) begin
        exp_q       = bubble_pl();
        stall_taken = 1'b1;
        m_stall_cnt = m_stall_cnt + 1;
      end else begin
        exp_q       = in.valid ? in : bubble_pl();
        stall_taken = 1'b0;
      end
      if (!exp_q.valid) m_bubble_cnt = m_bubble_cnt + 1;
    end
    #1;
    check("valid",    64'(ds_es_o_valid),    64'(exp_q.valid));
    check("opcode",   64'(ds_es_o_opcode),   64'(exp_q.opcode));
    check("rs1",      64'(ds_es_o_addr_rs1), 64'(exp_q.rs1));
    check("rs2",      64'(ds_es_o_addr_rs2), 64'(exp_q.rs2));
    check("rd",       64'(ds_es_o_addr_rd),  64'(exp_q.rd));
    check("regwrite", 64'(ds_es_o_regwrite), 64'(exp_q.regwrite));
    check("data_rs1", 64'(ds_es_o_data_rs1), 64'(exp_q.d1));
    check("data_rs2", 64'(ds_es_o_data_rs2), 64'(exp_q.d2));
    check("imm",      64'(ds_es_o_imm),      64'(exp_q.imm));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt",  64'(h_o_stall_cnt),  64'(m_stall_cnt));
    check("flush_cnt",  64'(h_o_flush_cnt),  64'(m_flush_cnt));
    check("bubble_cnt", 64'(h_o_bubble_cnt), 64'(m_bubble_cnt));
`endif
  endtask

  initial begin
    pl_t p, q, idle;
    idle = '0;

    // Reset with random inputs, then a quiet cycle with fixed expectations.
    step(1'b1, rand_pl(), 1'($urandom), 1'($urandom));
    step(1'b1, rand_pl(), 1'($urandom), 1'($urandom));
    #1;
    i_rst = 1'b0; f_i_stall = 1'b0; es_i_flush = 1'b0; #1;
    check("rst_valid",    64'(ds_es_o_valid),    64'd0);
    check("rst_opcode",   64'(ds_es_o_opcode),   64'(NOP));
    check("rst_regwrite", 64'(ds_es_o_regwrite), 64'd0);
    check("rst_pc_en",    64'(h_o_pc_en),        64'd1);
    check("rst_fd_en",    64'(h_o_fd_en),        64'd1);
    check("rst_fd_flush", 64'(h_o_fd_flush),     64'd0);

    // Normal flow.
    p = '{valid: 1'b1, opcode: 6'h23, rs1: 5'd3, rs2: 5'd4, rd: 5'd5, regwrite: 1'b1,
          d1: 32'h11, d2: 32'h22, imm: 32'hFFFF_FFF0};
    step(1'b0, p, 1'b0, 1'b0);
    check("nf_opcode", 64'(ds_es_o_opcode), 64'h23);
    check("nf_rd",     64'(ds_es_o_addr_rd), 64'd5);

    // Load-use: stall held two cycles while decode holds an rd=7 instruction.
    q = p; q.rd = 5'd7; q.opcode = 6'h05;
    step(1'b0, q, 1'b1, 1'b0);
    check("lu_bubble", 64'(ds_es_o_valid), 64'd0);
    step(1'b0, q, 1'b1, 1'b0);
    check("lu_held_rd", 64'(ds_es_o_addr_rd), 64'd7);
    step(1'b0, p, 1'b0, 1'b0);
    check("lu_no_third_bubble", 64'(ds_es_o_valid), 64'd1);

    // Branch flush: two bubbles, then capture.
    step(1'b0, p, 1'b0, 1'b1);
    step(1'b0, p, 1'b0, 1'b0);
    check("fl_second_bubble", 64'(ds_es_o_valid), 64'd0);
    step(1'b0, p, 1'b0, 1'b0);
    check("fl_resume", 64'(ds_es_o_valid), 64'd1);

    // Flush and stall together: flush wins.
    step(1'b0, p, 1'b1, 1'b1);
    step(1'b0, p, 1'b1, 1'b0);
    step(1'b0, p, 1'b0, 1'b0);

    // Reset while FLUSH has one bubble left.
    step(1'b0, p, 1'b0, 1'b1);
    step(1'b1, p, 1'b1, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    step(1'b0, p, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2, rand_pl(),
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 12);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ds_es_hazard_stage.md
Name: ds_es_hazard_stage

Overview:
- Decode-to-execute pipeline register plus hazard controller. It is the consumer of the forwarding unit's load-use stall request.
- Captures decoded fields from decode. On stall or branch flush it converts them into bubbles, and it drives hold enables back to fetch and decode.
- Its registered outputs (opcode, rs1/rs2/rd addresses, regwrite) feed execute and are the ds_es_* inputs the forwarding unit compares against.

Parameters:
- AWIDTH, 5, register address width
- DWIDTH, 32, operand/immediate width
- OPCODE_WIDTH, 6, opcode width
- NOP_OPCODE, 0, opcode driven for a bubble
- FLUSH_CYCLES, 2, bubbles inserted per branch flush (1..7)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- d_i_valid  in  1  decode presents a valid instruction
- d_i_opcode  in  OPCODE_WIDTH  decoded opcode
- d_i_addr_rs1  in  AWIDTH  source 1 address
- d_i_addr_rs2  in  AWIDTH  source 2 address
- d_i_addr_rd  in  AWIDTH  destination address
- d_i_regwrite  in  1  instruction writes rd
- d_i_data_rs1  in  DWIDTH  register file read 1
- d_i_data_rs2  in  DWIDTH  register file read 2
- d_i_imm  in  DWIDTH  sign-extended immediate
- f_i_stall  in  1  load-use stall request from forwarding
- es_i_flush  in  1  branch/jump taken, resolved in execute
- ds_es_o_valid  out  1  registered valid
- ds_es_o_opcode  out  OPCODE_WIDTH  registered opcode
- ds_es_o_addr_rs1  out  AWIDTH  registered rs1
- ds_es_o_addr_rs2  out  AWIDTH  registered rs2
- ds_es_o_addr_rd  out  AWIDTH  registered rd
- ds_es_o_regwrite  out  1  registered regwrite
- ds_es_o_data_rs1  out  DWIDTH  registered operand 1
- ds_es_o_data_rs2  out  DWIDTH  registered operand 2
- ds_es_o_imm  out  DWIDTH  registered immediate
- h_o_pc_en  out  1  fetch PC update enable
- h_o_fd_en  out  1  fetch/decode register enable
- h_o_fd_flush  out  1  clear fetch/decode register

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - Reset applies at the next rising edge and overrides everything, including mid-stall and mid-flush.
  - Reset values: all ds_es_o_* = 0, opcode = NOP_OPCODE, state = RUN, flush counter = 0.
- Bubble definition:
  - valid=0, regwrite=0, opcode=NOP_OPCODE, all addresses 0, data/imm 0.
  - A bubble must never match a nonzero rd in forwarding.
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - es_i_flush=1: register a bubble, load counter with FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES=1, stay in RUN instead.
  - Else f_i_stall=1: register a bubble, go to STALL.
  - Else: register d_i_* when d_i_valid=1, otherwise register a bubble. One-cycle latency input to output.
- STALL (exactly one cycle):
  - Decode is still presenting the held instruction. Capture it normally and return to RUN.
  - f_i_stall is ignored in STALL, so the same hazard cannot deadlock the pipe.
  - es_i_flush in STALL behaves as in RUN: flush wins.
- FLUSH:
  - Register bubbles while counter>0, decrementing each cycle. Go to RUN when counter reaches 0.
  - es_i_flush while in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - f_i_stall is ignored in FLUSH.
- Combinational hold outputs, from the current state and inputs:
  - h_o_pc_en = h_o_fd_en = 0 when (state==RUN && f_i_stall && !es_i_flush). Otherwise 1.
  - h_o_fd_flush = es_i_flush || state==FLUSH.
- Priority order: reset > flush > stall > normal capture.
- Operand data is passed through unmodified. This block does not select forwarded values; execute's mux does.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs:
  - h_o_stall_cnt [31:0]: +1 on each cycle entering STALL.
  - h_o_flush_cnt [31:0]: +1 on each es_i_flush=1 cycle.
  - h_o_bubble_cnt [31:0]: +1 on each registered bubble.
- Counters wrap at 2^32, reset to 0 with i_rst, and update on the same edge as the state.
- When not defined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold i_rst 2 cycles with random inputs -> ds_es_o_valid=0, opcode=NOP_OPCODE, regwrite=0, h_o_pc_en=1, h_o_fd_en=1, h_o_fd_flush=0.
- Normal flow: d_i_valid=1, opcode=0x23, rs1=3, rs2=4, rd=5, regwrite=1, data_rs1=0x11 -> same values on outputs one cycle later.
- Load-use: f_i_stall=1 for 2 consecutive cycles while decode holds rd=7 instruction -> cycle1 pc_en=fd_en=0 and bubble registered. Cycle2 stall ignored, pc_en=1, held instruction registered. No third bubble.
- Branch flush, FLUSH_CYCLES=2: es_i_flush=1 for one cycle -> exactly 2 consecutive bubbles, h_o_fd_flush high for 2 cycles, then normal capture.
- Flush and stall in the same cycle -> flush wins: pc_en=1, state FLUSH, 2 bubbles.
- Reset asserted in FLUSH with counter=1 -> next edge state RUN, outputs at reset values. With HAZARD_PERF_CNT_EN, all counters read 0.
